// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default line constants and the divider helper.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ  = 27_000_000;
  localparam int unsigned UART_BAUD      = 115_200;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

  // Truncated clocks-per-bit; the fractional remainder is deliberately dropped.
  function automatic int unsigned uart_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last clock of each bit.
// Shared between the transmitter and the future receiver; BAUD_DIV must be >= 2.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 234
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    if (clear || (cnt == LAST)) begin
      cnt_d = '0;
    end
  end

  // bit_tick is registered from the next count so it is high exactly while cnt == LAST.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      bit_tick <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a start/done handshake and registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
  parameter int unsigned BAUD     = UART_BAUD
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int unsigned BAUD_DIV = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state, state_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic [IDX_W-1:0]          idx, idx_d;
  logic                      done_d, busy_d, txd_d;
  logic                      baud_clear;
  logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                      par, par_d;
`endif

  // Counter is held at zero while idle so the start bit gets a full period.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      shift    <= '0;
      idx      <= '0;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
      uart_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      idx      <= idx_d;
      tx_done  <= done_d;
      tx_busy  <= busy_d;
      uart_txd <= txd_d;
`ifdef UART_TX_PARITY_EN
      par      <= par_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state;
    shift_d = shift;
    idx_d   = idx;
    done_d  = 1'b0;
    busy_d  = tx_busy;
    txd_d   = uart_txd;
`ifdef UART_TX_PARITY_EN
    par_d   = par;
`endif
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
        if (tx_start) begin
          shift_d = tx_data;
          state_d = START;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift[UART_DATA_BITS-1:1]};
          idx_d   = idx + IDX_W'(1);
          txd_d   = shift[1];
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule
